mmc_dat_deserialiser: RTL and testbench

Receive-direction companion of the DAT write serialiser. It samples the MMC/SD DAT line(s) on rising edges of the card bit clock and hunts for the start bit. It then deserialises 512-byte data blocks into a byte stream, checks the per-line CRC16 and the end bit, and handles multi-block reads. It sits between the pad-level DAT inputs and the host read FIFO.

---
 rtl/mmc_dat_deserialiser_if.sv | 24 ++
 rtl/mmc_dat_deserialiser.sv | 189 ++++++++++++++++++
 tb/tb_mmc_dat_deserialiser.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/mmc_dat_deserialiser_if.sv
// Host-side bundle of the DAT read deserialiser: read control in, byte stream and status out.
// "master" is the host/FIFO controller, "slave" is the deserialiser itself.
interface mmc_dat_deserialiser_if;
   logic       start_i;
   logic       abort_i;
   logic       mode_4bit_i;
   logic [7:0] block_cnt_i;
   logic [7:0] data_o;
   logic       valid_o;
   logic       active_o;
   logic       complete_o;
   logic       crc_err_o;
   logic       timeout_o;

   modport master (
      output start_i, abort_i, mode_4bit_i, block_cnt_i,
      input  data_o, valid_o, active_o, complete_o, crc_err_o, timeout_o
   );

   modport slave (
      input  start_i, abort_i, mode_4bit_i, block_cnt_i,
      output data_o, valid_o, active_o, complete_o, crc_err_o, timeout_o
   );
endinterface

// File: rtl/mmc_dat_deserialiser.sv
// MMC/SD DAT receive path: start-bit hunt, 512-byte block deserialise, per-line CRC16 and end-bit check.
// Optional 4-line mode is built only when MMC_DAT_DESER_4BIT_EN is defined.

module mmc_crc16 (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        clr_i,
   input  logic        en_i,
   input  logic        bit_i,
   output logic [15:0] crc_o
);
   logic fb;

   assign fb = crc_o[15] ^ bit_i;

   always_ff @(posedge clk_i) begin
      if (rst_i || clr_i) crc_o <= '0;
      else if (en_i)      crc_o <= {crc_o[14:0], 1'b0} ^ ({16{fb}} & 16'h1021);
   end
endmodule

// state   | meaning
// IDLE    | waiting for start_i
// WAIT    | hunting for the start bit on DAT0, timeout counter running
// DATA    | shifting in 512 bytes, CRCs accumulating
// CRC     | comparing 16 received CRC bits per active line
// END     | end-bit check, block bookkeeping
module mmc_dat_deserialiser #(
   parameter logic [15:0] START_TIMEOUT = 16'd65535
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       bitclk_i,
   input  logic [3:0] dat_i,
   mmc_dat_deserialiser_if.slave bus
);
   typedef enum logic [2:0] {ST_IDLE, ST_WAIT, ST_DATA, ST_CRC, ST_END} state_t;

   state_t      state, state_n;
   logic        clk_q, sample_w, mode4_q, mode4_n, blk_err;
   logic [7:0]  blk_left, shift_q, shift_n;
   logic [12:0] samp_cnt;
   logic [2:0]  bit_cnt;
   logic [15:0] wait_cnt;
   logic        go, start_hit, wait_miss, wait_tc, data_smp, crc_smp, end_fire;
   logic        byte_done, last_smp, crc_bad, end_bad, crc_clr;

`ifdef MMC_DAT_DESER_4BIT_EN
   localparam int NLINE = 4;
   assign mode4_n = bus.mode_4bit_i;
   assign shift_n = mode4_q ? {shift_q[3:0], dat_i} : {shift_q[6:0], dat_i[0]};
   assign end_bad = mode4_q ? ~&dat_i : ~dat_i[0];
`else
   localparam int NLINE = 1;
   logic unused_hi;
   assign unused_hi = ^{dat_i[3:1], bus.mode_4bit_i};
   assign mode4_n   = 1'b0;
   assign shift_n   = {shift_q[6:0], dat_i[0]};
   assign end_bad   = ~dat_i[0];
`endif

   assign sample_w  = bitclk_i & ~clk_q;
   assign last_smp  = (samp_cnt == 13'd0);
   assign byte_done = data_smp & (mode4_q ? bit_cnt[0] : &bit_cnt);
   assign crc_clr   = go | end_fire;

   logic [15:0] crc_w [NLINE];

   for (genvar l = 0; l < NLINE; l++) begin : g_crc
      mmc_crc16 u_crc (
         .clk_i (clk_i),
         .rst_i (rst_i),
         .clr_i (crc_clr),
         .en_i  (data_smp && ((l == 0) || mode4_q)),
         .bit_i (dat_i[l]),
         .crc_o (crc_w[l])
      );
   end

   // samp_cnt counts 15..0 during CRC, so its low nibble is the CRC bit index (MSB first)
   always_comb begin
      crc_bad = 1'b0;
      for (int l = 0; l < NLINE; l++) begin
         if (((l == 0) || mode4_q) && (dat_i[l] != crc_w[l][samp_cnt[3:0]])) crc_bad = 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) state <= ST_IDLE;
      else       state <= state_n;
   end

   always_comb begin
      state_n = state;
      if (bus.abort_i) begin
         state_n = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: if (go) state_n = ST_WAIT;
            ST_WAIT: begin
               if (start_hit)    state_n = ST_DATA;
               else if (wait_tc) state_n = ST_IDLE;
            end
            ST_DATA: if (data_smp && last_smp) state_n = ST_CRC;
            ST_CRC:  if (crc_smp && last_smp)  state_n = ST_END;
            ST_END:  if (end_fire) state_n = (blk_left == 8'd1) ? ST_IDLE : ST_WAIT;
            default: state_n = ST_IDLE;
         endcase
      end
   end

   // Abort masks every strobe, so it can never emit a byte or a completion
   always_comb begin
      go           = 1'b0;
      start_hit    = 1'b0;
      wait_miss    = 1'b0;
      wait_tc      = 1'b0;
      data_smp     = 1'b0;
      crc_smp      = 1'b0;
      end_fire     = 1'b0;
      bus.active_o = (state != ST_IDLE);
      if (!bus.abort_i) begin
         case (state)
            ST_IDLE: go = bus.start_i;
            ST_WAIT: begin
               start_hit = sample_w & ~dat_i[0];
               wait_miss = sample_w & dat_i[0];
               wait_tc   = wait_miss & ((wait_cnt + 16'd1) == START_TIMEOUT);
            end
            ST_DATA: data_smp = sample_w;
            ST_CRC:  crc_smp  = sample_w;
            ST_END:  end_fire = sample_w;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         clk_q          <= 1'b0;
         mode4_q        <= 1'b0;
         blk_left       <= 8'd0;
         shift_q        <= 8'd0;
         samp_cnt       <= 13'd0;
         bit_cnt        <= 3'd0;
         wait_cnt       <= 16'd0;
         blk_err        <= 1'b0;
         bus.data_o     <= 8'd0;
         bus.valid_o    <= 1'b0;
         bus.complete_o <= 1'b0;
         bus.crc_err_o  <= 1'b0;
         bus.timeout_o  <= 1'b0;
      end else begin
         clk_q          <= bitclk_i;
         bus.valid_o    <= byte_done;
         bus.complete_o <= end_fire && (blk_left == 8'd1);
         if (byte_done) bus.data_o <= shift_n;
         if (go) begin
            mode4_q       <= mode4_n;
            blk_left      <= (bus.block_cnt_i == 8'd0) ? 8'd1 : bus.block_cnt_i;
            bus.crc_err_o <= 1'b0;
            bus.timeout_o <= 1'b0;
            wait_cnt      <= 16'd0;
            blk_err       <= 1'b0;
         end
         if (start_hit) begin
            wait_cnt <= 16'd0;
            bit_cnt  <= 3'd0;
            samp_cnt <= mode4_q ? 13'd1023 : 13'd4095;
         end
         if (wait_miss) wait_cnt <= wait_cnt + 16'd1;
         if (wait_tc)   bus.timeout_o <= 1'b1;
         if (data_smp) begin
            shift_q  <= shift_n;
            bit_cnt  <= bit_cnt + 3'd1;
            samp_cnt <= last_smp ? 13'd15 : samp_cnt - 13'd1;
         end
         if (crc_smp) begin
            if (crc_bad)   blk_err  <= 1'b1;
            if (!last_smp) samp_cnt <= samp_cnt - 13'd1;
         end
         if (end_fire) begin
            bus.crc_err_o <= bus.crc_err_o | blk_err | end_bad;
            blk_left      <= blk_left - 8'd1;
            blk_err       <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_mmc_dat_deserialiser.sv
// Directed bench for mmc_dat_deserialiser: scenario table of whole reads plus hand sequences
// for timeout, abort, and reset corners. Expectations follow MMC_DAT_DESER_4BIT_EN if defined.
module tb_mmc_dat_deserialiser;
`ifdef MMC_DAT_DESER_4BIT_EN
   localparam bit HAS4 = 1'b1;
`else
   localparam bit HAS4 = 1'b0;
`endif

   typedef struct {
      logic       mode4;
      logic [7:0] cnt;
      int         pat;        // 0: byte = index, 1: all 0xA5
      int         flip;       // CRC bit to invert on DAT0, -1 none
      int         badend;     // DAT line with a low end bit, -1 none
      int         exp_blocks;
      logic       exp_err;
   } scn_t;

   logic       clk_i = 1'b0;
   logic       rst_i = 1'b1;
   logic       bitclk_i = 1'b0;
   logic [3:0] dat_i = 4'hF;
   int         n_chk = 0;
   int         n_fail = 0;
   int         n_valid = 0;
   int         n_cmp = 0;
   scn_t       tbl[$];

   mmc_dat_deserialiser_if bus();

   mmc_dat_deserialiser #(.START_TIMEOUT(16'd16)) dut (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .bitclk_i (bitclk_i),
      .dat_i    (dat_i),
      .bus      (bus)
   );

   always #5 clk_i = ~clk_i;

   always @(negedge clk_i) begin
      if (bus.valid_o)    n_valid <= n_valid + 1;
      if (bus.complete_o) n_cmp   <= n_cmp + 1;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog actual=running expected=finished");
      $fatal(1, "watchdog");
   end

   function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic b);
      return {c[14:0], 1'b0} ^ ((c[15] ^ b) ? 16'h1021 : 16'h0000);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // One card bit-clock period (2 clk_i cycles); returns on the negedge after the sample edge
   task automatic smp(input logic [3:0] d);
      @(negedge clk_i);
      dat_i    = d;
      bitclk_i = 1'b1;
      @(negedge clk_i);
      bitclk_i = 1'b0;
   endtask

   task automatic start_rd(input logic mode4, input logic [7:0] cnt);
      @(negedge clk_i);
      bus.start_i     = 1'b1;
      bus.mode_4bit_i = mode4;
      bus.block_cnt_i = cnt;
      @(negedge clk_i);
      bus.start_i = 1'b0;
   endtask

   task automatic send_block(input logic e4, input int pat, input int flip, input int badend, input int stop);
      logic [15:0] crc [4];
      logic [7:0]  b;
      logic [3:0]  d, nib;
      for (int l = 0; l < 4; l++) crc[l] = 16'h0000;
      smp(4'hF);
      smp(4'hF);
      smp(4'h0);
      for (int i = 0; i < 512; i++) begin
         b = (pat == 1) ? 8'hA5 : i[7:0];
         if (i == stop) begin
            for (int k = 0; k < 3; k++) smp(4'hF);
            return;
         end
         if (e4) begin
            for (int h = 1; h >= 0; h--) begin
               nib = (h == 1) ? b[7:4] : b[3:0];
               for (int l = 0; l < 4; l++) crc[l] = crc_upd(crc[l], nib[l]);
               smp(nib);
            end
         end else begin
            for (int k = 7; k >= 0; k--) begin
               crc[0] = crc_upd(crc[0], b[k]);
               smp({3'b111, b[k]});
            end
         end
         chk("byte_valid", bus.valid_o, 1'b1);
         chk("byte_data", bus.data_o, b);
      end
      for (int k = 15; k >= 0; k--) begin
         d = e4 ? {crc[3][k], crc[2][k], crc[1][k], crc[0][k]} : {3'b111, crc[0][k]};
         if (k == flip) d[0] = ~d[0];
         smp(d);
      end
      d = 4'hF;
      if (badend >= 0) d[badend] = 1'b0;
      smp(d);
   endtask

   task automatic run_scn(input scn_t s);
      int v0, c0;
      logic e4;
      e4 = s.mode4 & HAS4;
      v0 = n_valid;
      c0 = n_cmp;
      start_rd(s.mode4, s.cnt);
      chk("active_rise", bus.active_o, 1'b1);
      chk("err_cleared", bus.crc_err_o, 1'b0);
      chk("to_cleared", bus.timeout_o, 1'b0);
      for (int k = 0; k < s.exp_blocks; k++) begin
         send_block(e4, s.pat, s.flip, s.badend, 512);
         chk("complete_at_end", bus.complete_o, (k == s.exp_blocks - 1));
         chk("active_at_end", bus.active_o, (k != s.exp_blocks - 1));
      end
      @(negedge clk_i);
      chk("crc_err", bus.crc_err_o, s.exp_err);
      chk("byte_count", n_valid - v0, 512 * s.exp_blocks);
      chk("complete_count", n_cmp - c0, 1);
   endtask

   initial begin
      int v0, c0;
      tbl.push_back('{1'b0, 8'd1, 0, -1, -1, 1, 1'b0});
      tbl.push_back('{1'b0, 8'd1, 0,  3, -1, 1, 1'b1});
      tbl.push_back('{1'b0, 8'd2, 1, -1, -1, 2, 1'b0});
`ifdef MMC_DAT_DESER_4BIT_EN
      tbl.push_back('{1'b1, 8'd0, 0, -1,  2, 1, 1'b1});
      tbl.push_back('{1'b1, 8'd2, 1, -1, -1, 2, 1'b0});
`else
      tbl.push_back('{1'b1, 8'd0, 0, -1,  2, 1, 1'b0});
`endif

      bus.start_i     = 1'b0;
      bus.abort_i     = 1'b0;
      bus.mode_4bit_i = 1'b0;
      bus.block_cnt_i = 8'd1;
      repeat (3) @(negedge clk_i);
      chk("rst_data", bus.data_o, 8'h00);
      chk("rst_valid", bus.valid_o, 1'b0);
      chk("rst_active", bus.active_o, 1'b0);
      chk("rst_complete", bus.complete_o, 1'b0);
      chk("rst_crc_err", bus.crc_err_o, 1'b0);
      chk("rst_timeout", bus.timeout_o, 1'b0);
      rst_i = 1'b0;

      // timeout; a low DAT0 sampled on the start cycle itself must not count as a start bit
      c0 = n_cmp;
      @(negedge clk_i);
      bus.start_i = 1'b1;
      dat_i       = 4'h0;
      bitclk_i    = 1'b1;
      @(negedge clk_i);
      bus.start_i = 1'b0;
      bitclk_i    = 1'b0;
      chk("to_active_rise", bus.active_o, 1'b1);
      repeat (15) smp(4'hF);
      chk("to_not_yet", bus.timeout_o, 1'b0);
      chk("to_still_active", bus.active_o, 1'b1);
      smp(4'hF);
      chk("to_set", bus.timeout_o, 1'b1);
      chk("to_idle", bus.active_o, 1'b0);
      @(negedge clk_i);
      chk("to_no_complete", n_cmp - c0, 0);

      // abort in IDLE wins over start and leaves sticky flags alone
      bus.abort_i = 1'b1;
      bus.start_i = 1'b1;
      @(negedge clk_i);
      bus.abort_i = 1'b0;
      bus.start_i = 1'b0;
      @(negedge clk_i);
      chk("abort_start_ignored", bus.active_o, 1'b0);
      chk("abort_keeps_timeout", bus.timeout_o, 1'b1);

      foreach (tbl[i]) run_scn(tbl[i]);

      // abort after 100 bytes, then a clean read
      v0 = n_valid;
      c0 = n_cmp;
      start_rd(1'b0, 8'd1);
      send_block(1'b0, 0, -1, -1, 100);
      bus.abort_i = 1'b1;
      @(negedge clk_i);
      bus.abort_i = 1'b0;
      chk("abort_idle", bus.active_o, 1'b0);
      @(negedge clk_i);
      chk("abort_bytes", n_valid - v0, 100);
      chk("abort_no_complete", n_cmp - c0, 0);
      run_scn(tbl[0]);

      // reset mid-block
      v0 = n_valid;
      start_rd(1'b0, 8'd1);
      send_block(1'b0, 0, -1, -1, 5);
      rst_i = 1'b1;
      @(negedge clk_i);
      chk("midrst_active", bus.active_o, 1'b0);
      chk("midrst_valid", bus.valid_o, 1'b0);
      chk("midrst_data", bus.data_o, 8'h00);
      rst_i = 1'b0;
      repeat (4) smp(4'h0);
      chk("midrst_bytes", n_valid - v0, 5);
      chk("midrst_stays_idle", bus.active_o, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end
endmodule
